hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Drives the ld/clr controls of the PC register and the IF/ID and ID/EX pipeline registers.
//  Detects load-use hazards, HI/LO use while mult/div is busy, ID-stage branch/jump redirects
//  and data-memory wait. Also keeps a saturating count of stall cycles.
//  Sits beside the ID stage. Its outputs feed the PCReg-style ld/clr ports.
// PARAMETERS
//  MULDIV_LAT  32  cycles the mult/div unit stays busy after id_muldiv_start (>=2)
//  STAT_W      16  width of stall_cnt
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       asynchronous, active-high reset
//  id_rs, id_rt     in   5       source register indices of the instruction in ID
//  id_uses_rs/rt    in   1       ID instruction reads rs / rt
//  id_uses_hilo     in   1       ID instruction is mfhi/mflo
//  id_muldiv_start  in   1       ID instruction is mult/div, issuing this cycle
//  id_redirect      in   1       taken branch or jump resolved in ID
//  ex_mem_read      in   1       instruction in EX is a load
//  ex_rt            in   5       destination of the load in EX
//  dmem_wait        in   1       data memory not ready; whole pipe must freeze
//  pc_ld, pc_clr    out  1       PC register load / clear
//  ifid_ld, ifid_clr out 1       IF/ID load / clear (bubble)
//  idex_ld, idex_clr out 1       ID/EX load / clear (bubble)
//  muldiv_busy      out  1       mult/div timer running
//  stall_cnt        out  STAT_W  saturating count of cycles with pc_ld==0 in S_RUN
// BEHAVIOUR
//  Reset is asynchronous and active-high. While rst is high:
//    state=S_INIT, timer=0, stall_cnt=0, muldiv_busy=0,
//    pc_ld=0, pc_clr=1, ifid_ld=0, ifid_clr=1, idex_ld=0, idex_clr=1.
//  FSM states: S_INIT, S_RUN.
//  S_INIT: lasts one cycle after rst deasserts. Outputs keep their reset values.
//    Next state is S_RUN unconditionally, so the pipe starts with clean bubbles.
//  S_RUN: outputs are combinational from inputs and registered state. Priority, highest first:
//   1 freeze: dmem_wait=1
//     -> all ld=0, all clr=0. Nothing moves. The timer still counts down.
//   2 stall: lu | hl
//     -> pc_ld=0, ifid_ld=0, idex_ld=1, idex_clr=1 (insert a bubble into EX).
//     lu = ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt))
//     hl = id_uses_hilo & muldiv_busy
//     Also asserted when id_muldiv_start & muldiv_busy (structural hazard).
//     A stall overrides id_redirect. The branch is re-evaluated after the stall clears.
//   3 redirect: id_redirect=1
//     -> pc_ld=1, ifid_ld=1, ifid_clr=1 (squash the fetched delay slot), idex_ld=1.
//   4 normal: pc_ld=ifid_ld=idex_ld=1, all clr=0.
//  pc_clr=0 in S_RUN.
//  Mult/div timer (width clog2(MULDIV_LAT+1)):
//    Loaded with MULDIV_LAT on a cycle where id_muldiv_start=1, no stall and no freeze.
//    Otherwise it decrements while nonzero, including during a freeze.
//    muldiv_busy = (timer != 0).
//  stall_cnt: +1 on every S_RUN cycle with pc_ld=0 (freeze or stall). Saturates at all-ones.
//    No wrap.
//  Register $0 never creates a load-use hazard.
// STRUCTURE
//  pipeline_pkg holds: the state encoding (S_INIT=0, S_RUN=1), REG_IDX_W=5, REG_ZERO=5'd0.
//  One sub-module, muldiv_timer: load/decrement/busy, parameterised by MULDIV_LAT.
//  Hazard compare logic and the stat counter live in hazard_ctrl.
// TESTING
//  1 rst pulse mid-run with timer=10 and stall_cnt=7
//    -> all outputs return to reset values immediately.
//    -> One S_INIT cycle follows, then pc_ld=1.
//  2 ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1
//    -> pc_ld=0, ifid_ld=0, idex_clr=1 for exactly one cycle. stall_cnt +1.
//    Repeat with ex_rt=0 -> no stall.
//  3 id_muldiv_start at cycle 0 (MULDIV_LAT=4), id_uses_hilo from cycle 1
//    -> stall in cycles 1..4. Normal flow in cycle 5. muldiv_busy falls with timer=0.
//  4 id_redirect=1 alone -> pc_ld=1, ifid_clr=1.
//    id_redirect=1 together with a load-use hazard -> stall only, ifid_clr=0.
//  5 dmem_wait held 3 cycles during a load-use hazard
//    -> all ld=0 and clr=0 for 3 cycles, then one stall cycle. stall_cnt +4.
//  6 Force stall_cnt to 16'hFFFE, then hold a stall 3 cycles -> stall_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types and constants for the hazard controller slice.
package pipeline_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // True when a source operand read in ID is the destination of the load in EX.
    function automatic logic src_hit(input logic uses,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_timer.sv
// Busy timer for the multi-cycle mult/div unit: loads the latency on issue, counts down to zero.
module muldiv_timer #(
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    localparam int unsigned TW = $clog2(MULDIV_LAT + 1);
    localparam logic [TW-1:0] LAT_V = TW'(MULDIV_LAT);
    localparam logic [TW-1:0] ONE   = TW'(1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (load) begin
            timer <= LAT_V;
        end else if (timer != '0) begin
            timer <= timer - ONE;
        end
    end

    assign busy = (timer != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: drives ld/clr of PC, IF/ID and ID/EX registers and counts stall cycles.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32,
    parameter int unsigned STAT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 id_uses_hilo,
    input  logic                 id_muldiv_start,
    input  logic                 id_redirect,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 dmem_wait,
    output logic                 pc_ld,
    output logic                 pc_clr,
    output logic                 ifid_ld,
    output logic                 ifid_clr,
    output logic                 idex_ld,
    output logic                 idex_clr,
    output logic                 muldiv_busy,
    output logic [STAT_W-1:0]    stall_cnt
);

    state_t state;
    logic   run;
    logic   freeze;
    logic   load_use;
    logic   hilo_use;
    logic   muldiv_struct;
    logic   stall;
    logic   timer_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= S_RUN;
        end
    end

    assign run    = (state == S_RUN);
    assign freeze = dmem_wait;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      (src_hit(id_uses_rs, id_rs, ex_rt) || src_hit(id_uses_rt, id_rt, ex_rt));
    assign hilo_use      = id_uses_hilo && muldiv_busy;
    assign muldiv_struct = id_muldiv_start && muldiv_busy;
    assign stall         = load_use || hilo_use || muldiv_struct;

    // A stalled or frozen mult/div issue is retried later, so it must not start the timer.
    assign timer_load = run && id_muldiv_start && !stall && !freeze;

    muldiv_timer #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(timer_load),
        .busy(muldiv_busy)
    );

    always_comb begin
        pc_ld    = 1'b0;
        pc_clr   = 1'b1;
        ifid_ld  = 1'b0;
        ifid_clr = 1'b1;
        idex_ld  = 1'b0;
        idex_clr = 1'b1;
        if (run) begin
            pc_clr = 1'b0;
            if (freeze) begin
                ifid_clr = 1'b0;
                idex_clr = 1'b0;
            end else if (stall) begin
                ifid_clr = 1'b0;
                idex_ld  = 1'b1;
                idex_clr = 1'b1;
            end else if (id_redirect) begin
                pc_ld    = 1'b1;
                ifid_ld  = 1'b1;
                ifid_clr = 1'b1;
                idex_ld  = 1'b1;
                idex_clr = 1'b0;
            end else begin
                pc_ld    = 1'b1;
                ifid_ld  = 1'b1;
                ifid_clr = 1'b0;
                idex_ld  = 1'b1;
                idex_clr = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (run && !pc_ld && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned LAT     = 4;
    localparam int unsigned SW      = 16;
    localparam int          CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_uses_hilo = 1'b0;
    logic        id_muldiv_start = 1'b0, id_redirect = 1'b0, ex_mem_read = 1'b0, dmem_wait = 1'b0;
    logic        pc_ld, pc_clr, ifid_ld, ifid_clr, idex_ld, idex_clr, muldiv_busy;
    logic [SW-1:0] stall_cnt;

    hazard_ctrl #(.MULDIV_LAT(LAT), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo), .id_muldiv_start(id_muldiv_start), .id_redirect(id_redirect),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .dmem_wait(dmem_wait),
        .pc_ld(pc_ld), .pc_clr(pc_clr), .ifid_ld(ifid_ld), .ifid_clr(ifid_clr),
        .idex_ld(idex_ld), .idex_clr(idex_clr), .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit [4:0] rs, rt, ert;
        bit       urs, urt, uhl, start, redir, mread, dwait;
    } stim_t;

    typedef struct {
        int       id;
        bit [5:0] ctl;    // {pc_ld,pc_clr,ifid_ld,ifid_clr,idex_ld,idex_clr}
        bit       busy;
        int       cnt;
    } exp_t;

    exp_t exq[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_id = 0;

    // Behavioural model: "in first cycle after reset", remaining busy cycles, stall total.
    bit   m_init  = 1'b1;
    int   m_left  = 0;
    int   m_cnt   = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic tick(input stim_t s);
        exp_t e;
        bit lu, hl, stl;
        @(posedge clk);
        #1;
        rst = s.rst; id_rs = s.rs; id_rt = s.rt; ex_rt = s.ert;
        id_uses_rs = s.urs; id_uses_rt = s.urt; id_uses_hilo = s.uhl;
        id_muldiv_start = s.start; id_redirect = s.redir; ex_mem_read = s.mread; dmem_wait = s.dwait;
        e.id = tick_id;
        tick_id++;
        if (s.rst) begin
            m_init = 1'b1; m_left = 0; m_cnt = 0;
            e.ctl = 6'b010101; e.busy = 1'b0; e.cnt = 0;
        end else if (m_init) begin
            e.ctl = 6'b010101; e.busy = (m_left != 0); e.cnt = m_cnt;
            m_init = 1'b0;
            if (m_left > 0) m_left--;
        end else begin
            e.busy = (m_left != 0);
            e.cnt  = m_cnt;
            lu  = s.mread && s.ert != 0 && ((s.urs && s.rs == s.ert) || (s.urt && s.rt == s.ert));
            hl  = s.uhl && (m_left != 0);
            stl = lu || hl || (s.start && m_left != 0);
            if (s.dwait)      e.ctl = 6'b000000;
            else if (stl)     e.ctl = 6'b000011;
            else if (s.redir) e.ctl = 6'b101110;
            else              e.ctl = 6'b101010;
            if (e.ctl[5] == 1'b0 && m_cnt < CNT_MAX) m_cnt++;
            if (s.start && !stl && !s.dwait) m_left = LAT;
            else if (m_left > 0)             m_left--;
        end
        exq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        bit [5:0] got;
        forever begin
            @(negedge clk);
            if (exq.size() > 0) begin
                e = exq.pop_front();
                got = {pc_ld, pc_clr, ifid_ld, ifid_clr, idex_ld, idex_clr};
                checks++;
                if (got !== e.ctl || muldiv_busy !== e.busy || stall_cnt !== SW'(e.cnt)) begin
                    errors++;
                    $display("FAIL outputs tick %0d: got ctl=%b busy=%b cnt=%0d, expected ctl=%b busy=%b cnt=%0d",
                             e.id, got, muldiv_busy, stall_cnt, e.ctl, e.busy, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        // Power-on reset, then the S_INIT cycle.
        s = idle(); s.rst = 1;
        tick(s); tick(s);
        s = idle();
        tick(s); tick(s);

        // Load-use on rs with r8: one stall, then clear.
        s = idle(); s.mread = 1; s.ert = 8; s.rs = 8; s.urs = 1;
        tick(s);
        s = idle(); tick(s);
        // Same on rt; then destination $0 never stalls.
        s = idle(); s.mread = 1; s.ert = 8; s.rt = 8; s.urt = 1; tick(s);
        s = idle(); s.mread = 1; s.ert = 0; s.rs = 0; s.urs = 1; s.rt = 0; s.urt = 1; tick(s);
        s = idle(); tick(s);

        // mult/div issue then mfhi from the next cycle: four stalls, then normal.
        s = idle(); s.start = 1; tick(s);
        s = idle(); s.uhl = 1;
        for (int i = 0; i < 6; i++) tick(s);
        // Back-to-back mult/div is a structural stall while busy.
        s = idle(); s.start = 1; tick(s); tick(s); tick(s);
        s = idle();
        for (int i = 0; i < 5; i++) tick(s);

        // Redirect alone, then redirect under a load-use hazard.
        s = idle(); s.redir = 1; tick(s);
        s.mread = 1; s.ert = 3; s.rt = 3; s.urt = 1; tick(s);
        s = idle(); tick(s);

        // Freeze three cycles during a load-use hazard, then a single stall.
        s = idle(); s.mread = 1; s.ert = 9; s.rs = 9; s.urs = 1; s.dwait = 1;
        tick(s); tick(s); tick(s);
        s.dwait = 0; tick(s);
        s = idle(); tick(s);

        // Reset pulse mid-run while the timer is running and stall_cnt is nonzero.
        s = idle(); s.start = 1; tick(s);
        s = idle(); s.uhl = 1; tick(s);
        s = idle(); s.rst = 1; tick(s);
        s = idle(); tick(s); tick(s); tick(s);

        // Randomized traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 99) < 2);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.ert   = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom_range(0, 1));
            s.urt   = 1'($urandom_range(0, 1));
            s.mread = ($urandom_range(0, 99) < 40);
            s.uhl   = ($urandom_range(0, 99) < 30);
            s.start = ($urandom_range(0, 99) < 15);
            s.redir = ($urandom_range(0, 99) < 20);
            s.dwait = ($urandom_range(0, 99) < 15);
            tick(s);
        end

        // Saturation: freeze long enough to pass all-ones, counter must stick.
        s = idle(); s.rst = 1; tick(s);
        s = idle(); tick(s);
        s.dwait = 1;
        for (int i = 0; i < CNT_MAX + 4; i++) tick(s);
        s = idle(); tick(s); tick(s);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exq.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
